fp32_scale_stim_gen: RTL and testbench
======================================

// Module: fp32_scale_stim_gen
// PURPOSE
//  Synthesizable FP32 stimulus generator for the MXINT8 block-conversion datapath.
//  Emits one pseudo-random IEEE-754 binary32 word per enabled cycle.
//  Mode controls force FP32 corner cases of the FP32->MXINT8 conversion:
//  round carry, tie-to-even, element saturation, shared-scale overflow, NaN/Inf,
//  zero and subnormal inputs.
//  Sits in front of the converter DUT in the bench/BIST path.
//  Element rounding point: keep mant[22:17], round bit mant[16], sticky bits mant[15:0].
// PARAMETERS
//  SEED  32'hACE1_2468  LFSR reset value; must be nonzero (0 is replaced by 32'h1)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   asynchronous, active-high reset
//  en           in   1   advance LFSR and register a new word this cycle
//  sign_i       in   1   sign bit placed in f[31]
//  carry_i      in   1   force round-up carry into kept mantissa bits
//  tie_i        in   1   force exact halfway (tie-to-even) pattern
//  ovf_i        in   1   force mantissa rounding overflow (element saturation)
//  scale_ovf_i  in   1   force overflow pattern at max finite exponent (scale carry)
//  nan_i        in   1   force exponent 8'hFF
//  zero_i       in   1   force mantissa to zero
//  subnorm_i    in   1   force exponent 8'h00
//  f            out  32  generated FP32 word {sign, exp[7:0], mant[22:0]}
//  valid_o      out  1   f updated this cycle (registered en)
// BEHAVIOUR
//  Reset: lfsr=SEED, f=32'h0, valid_o=0. Async assert; release synchronous to clk.
//  LFSR: 32-bit Galois, taps 32'h8020_0003, shifts once per cycle with en=1.
//  LFSR holds state when en=0.
//  On posedge with en=1, f <= word built from the next LFSR value r; valid_o <= 1.
//  On posedge with en=0, f holds and valid_o <= 0. Latency: one cycle from en.
//  Sign: f[31] = sign_i, sampled in the same cycle as en.
//  Exponent, first match wins:
//   1. nan_i -> 8'hFF
//   2. subnorm_i -> 8'h00
//   3. scale_ovf_i -> 8'hFE
//   4. otherwise r[30:23], clamped: 8'h00 becomes 8'h01, 8'hFF becomes 8'hFE
//  Mantissa base m = r[22:0]; overrides, first match wins:
//   1. zero_i -> 23'h0
//   2. ovf_i or scale_ovf_i -> m[22:16] = 7'h7F, m[0] = 1
//      (kept bits all ones, round 1, sticky nonzero -> rounds to 2.0)
//   3. carry_i -> m[17] = 1, m[16] = 1, m[0] = 1, m[22] = 0
//      (round-up carries into kept bits, no overflow)
//   4. tie_i -> m[16] = 1, m[15:0] = 0
//      (exact tie; m[17] stays random, so both even and odd cases occur)
//   5. none -> m unchanged
//  Combinations are legal:
//   nan_i & zero_i -> infinity (exp FF, mant 0)
//   subnorm_i & zero_i -> signed zero
//   nan_i & ovf_i -> NaN with overflow mantissa
//  Controls are sampled only when en=1; changing them with en=0 has no effect on f.
//  Reset during operation clears f and valid_o immediately and restores lfsr to SEED.
//  The random sequence is therefore reproducible after every reset.
//  No combinational path from inputs to outputs.
// TESTING
//  - Reset, then en=1 with all controls 0 for 10 cycles
//    -> every f has exp in 1..254, valid_o=1 one cycle after en.
//    Re-run after a second reset -> identical sequence.
//  - carry_i=1, sign_i=0 then 1 -> f[16]=1, f[17]=1, f[0]=1, f[22]=0, f[31]=0 then 1.
//  - tie_i=1 for 4 cycles, sign toggling -> f[16]=1, f[15:0]=0, f[31] alternates.
//  - scale_ovf_i=1 -> f[30:23]=8'hFE and f[22:16]=7'h7F.
//    ovf_i alone -> same mantissa, exponent random in 1..254.
//  - nan_i=1 -> f[30:23]=8'hFF.
//    nan_i=1 & zero_i=1, sign 1 -> f=32'hFF80_0000.
//  - subnorm_i=1 & zero_i=1, sign 0 then 1 -> f=32'h0000_0000 then 32'h8000_0000.
//    subnorm_i alone -> exp 0.

Source files
------------

// File: rtl/fp32_scale_stim_gen.sv
// FP32 stimulus source for the MXINT8 converter: Galois LFSR words with
// forced exponent/mantissa corner cases (carry, tie, saturation, NaN, zero).
module fp32_scale_stim_gen #(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        sign_i,
    input  logic        carry_i,
    input  logic        tie_i,
    input  logic        ovf_i,
    input  logic        scale_ovf_i,
    input  logic        nan_i,
    input  logic        zero_i,
    input  logic        subnorm_i,
    output logic [31:0] f,
    output logic        valid_o
);

    localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] TAPS    = 32'h8020_0003;

    logic [31:0] lfsr;
    logic [31:0] r;
    logic [7:0]  exp_n;
    logic [22:0] man_n;

    always_comb begin
        r = {1'b0, lfsr[31:1]};
        if (lfsr[0])
            r = r ^ TAPS;
    end

    always_comb begin
        exp_n = r[30:23];
        if (nan_i)
            exp_n = 8'hFF;
        else if (subnorm_i)
            exp_n = 8'h00;
        else if (scale_ovf_i)
            exp_n = 8'hFE;
        else if (r[30:23] == 8'h00)
            exp_n = 8'h01;
        else if (r[30:23] == 8'hFF)
            exp_n = 8'hFE;
    end

    // Mantissa overrides target the rounding point at bit 16
    always_comb begin
        man_n = r[22:0];
        if (zero_i) begin
            man_n = 23'h0;
        end else if (ovf_i || scale_ovf_i) begin
            man_n[22:16] = 7'h7F;
            man_n[0]     = 1'b1;
        end else if (carry_i) begin
            man_n[22] = 1'b0;
            man_n[17] = 1'b1;
            man_n[16] = 1'b1;
            man_n[0]  = 1'b1;
        end else if (tie_i) begin
            man_n[16]   = 1'b1;
            man_n[15:0] = 16'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr    <= SEED_NZ;
            f       <= 32'h0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= en;
            if (en) begin
                lfsr <= r;
                f    <= {sign_i, exp_n, man_n};
            end
        end
    end

endmodule

// File: tb/tb_fp32_scale_stim_gen.sv
// Directed bench for fp32_scale_stim_gen: reference LFSR plus
// field-level checks of every corner-case override.
module tb_fp32_scale_stim_gen;

    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [7:0] SG = 8'h80, CA = 8'h40, TI = 8'h20, OV = 8'h10;
    localparam logic [7:0] SO = 8'h08, NA = 8'h04, ZE = 8'h02, SN = 8'h01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        sign_i = 1'b0, carry_i = 1'b0, tie_i = 1'b0, ovf_i = 1'b0;
    logic        scale_ovf_i = 1'b0, nan_i = 1'b0, zero_i = 1'b0, subnorm_i = 1'b0;
    logic [31:0] f;
    logic        valid_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_lfsr;
    logic [31:0] m_f;
    logic        m_v;
    logic [31:0] seq [10];

    always #5 clk = ~clk;

    fp32_scale_stim_gen #(.SEED(SEED)) dut (
        .clk(clk), .rst(rst), .en(en), .sign_i(sign_i), .carry_i(carry_i),
        .tie_i(tie_i), .ovf_i(ovf_i), .scale_ovf_i(scale_ovf_i),
        .nan_i(nan_i), .zero_i(zero_i), .subnorm_i(subnorm_i),
        .f(f), .valid_o(valid_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n ^= 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [31:0] build(input logic [31:0] r,
                                          input logic [7:0] c);
        logic [7:0]  e;
        logic [22:0] m;
        if (c[2])                  e = 8'hFF;
        else if (c[0])             e = 8'h00;
        else if (c[3])             e = 8'hFE;
        else if (r[30:23] == 8'h0) e = 8'h01;
        else if (r[30:23] == 8'hFF) e = 8'hFE;
        else                       e = r[30:23];
        m = r[22:0];
        if (c[1]) m = 23'h0;
        else if (c[4] || c[3]) begin m[22:16] = 7'h7F; m[0] = 1'b1; end
        else if (c[6]) begin m[22] = 0; m[17] = 1; m[16] = 1; m[0] = 1; end
        else if (c[5]) begin m[16] = 1'b1; m[15:0] = 16'h0; end
        return {c[7], e, m};
    endfunction

    task automatic step(input logic e, input logic [7:0] c);
        en = e;
        {sign_i, carry_i, tie_i, ovf_i, scale_ovf_i, nan_i, zero_i, subnorm_i} = c;
        @(posedge clk);
        #1;
        if (e) begin
            m_lfsr = nxt(m_lfsr);
            m_f = build(m_lfsr, c);
            m_v = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        chk("valid", {31'b0, valid_o}, {31'b0, m_v});
        chk("word", f, m_f);
    endtask

    task automatic do_reset();
        en = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_f", f, 32'h0);
        chk("rst_valid", {31'b0, valid_o}, 32'h0);
        m_lfsr = SEED;
        m_f = 32'h0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic in_rng(input logic [31:0] w);
        return (w[30:23] >= 8'd1) && (w[30:23] <= 8'd254);
    endfunction

    initial begin
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h00);
            seq[i] = f;
            chk("exp_rng", {31'b0, in_rng(f)}, 32'h1);
        end
        step(1'b0, NA | ZE | SG);
        step(1'b0, OV);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h00);
            chk("repeat", f, seq[i]);
        end

        step(1'b1, CA);
        chk("carry0", {27'b0, f[31], f[22], f[17], f[16], f[0]}, 32'b00111);
        step(1'b1, CA | SG);
        chk("carry1", {27'b0, f[31], f[22], f[17], f[16], f[0]}, 32'b10111);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, TI | ((i % 2) ? SG : 8'h00));
            chk("tie", {14'b0, f[31], f[16], f[15:0]},
                {14'b0, 1'(i % 2), 1'b1, 16'h0});
        end

        step(1'b1, SO);
        chk("sovf", {17'b0, f[30:23], f[22:16]}, {17'b0, 8'hFE, 7'h7F});
        step(1'b1, OV);
        chk("ovf_m", {25'b0, f[22:16]}, 32'h7F);
        chk("ovf_e", {31'b0, in_rng(f)}, 32'h1);

        step(1'b1, NA);
        chk("nan_e", {24'b0, f[30:23]}, 32'hFF);
        step(1'b1, NA | ZE | SG);
        chk("inf", f, 32'hFF80_0000);
        step(1'b1, NA | OV);
        chk("nan_ovf", {17'b0, f[30:23], f[22:16]}, {17'b0, 8'hFF, 7'h7F});

        step(1'b1, SN | ZE);
        chk("pzero", f, 32'h0000_0000);
        step(1'b1, SN | ZE | SG);
        chk("nzero", f, 32'h8000_0000);
        step(1'b1, SN);
        chk("sub_e", {24'b0, f[30:23]}, 32'h0);

        step(1'b1, 8'h00);
        rst = 1'b1;
        #1;
        chk("async_f", f, 32'h0);
        chk("async_v", {31'b0, valid_o}, 32'h0);
        m_lfsr = SEED;
        m_f = 32'h0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 8'h00);
        chk("reseq", f, seq[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
